// File: rtl/axis_gen_pkg.sv
// axis_gen_pkg: shared definitions for the AXI4-Stream packet generator.
//   - APB register indices (paddr[4:2]) and CTRL/STATUS/CFG bit positions
//   - generator FSM state encoding
//   - register reset values and a small saturating-increment helper
package axis_gen_pkg;

  // word index = byte offset >> 2
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LEN    = 3'd1;
  localparam logic [2:0] REG_NPKT   = 3'd2;
  localparam logic [2:0] REG_SEED   = 3'd3;
  localparam logic [2:0] REG_CFG    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_BEATS  = 3'd6;
  localparam logic [2:0] REG_BAD    = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_STOP    = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_DONE  = 1;
  localparam int STATUS_PKT_LSB = 16;

  localparam int CFG_DEST_LSB = 16;

  localparam int LEN_RST = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } gen_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_gen_apb_regs.sv
// axis_gen_apb_regs: APB slave and register file for axis_stream_gen.
//   APB : psel/penable/paddr/pwrite/pwdata in, prdata/pready/pslverr out.
//         Zero wait states; prdata is combinational while psel is high.
//   Out : start_p/stop_p one-cycle pulses (registered from the CTRL write),
//         live config (cont, irq_en, len, npkt, seed, tid, dest_en), irq.
//   In  : busy, done_set (FSM in DONE), pkt_count, beat_count for STATUS/BEATS.
module axis_gen_apb_regs
  import axis_gen_pkg::*;
#(
  parameter int DEST_W = 2,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 16
) (
  input  logic                     ACLK,
  input  logic                     RSTN,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [31:0]              paddr,
  input  logic                     pwrite,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  input  logic                     busy,
  input  logic                     done_set,
  input  logic [15:0]              pkt_count,
  input  logic [31:0]              beat_count,
  output logic                     start_p,
  output logic                     stop_p,
  output logic                     cont,
  output logic                     irq_en,
  output logic [LEN_W-1:0]         len,
  output logic [LEN_W-1:0]         npkt,
  output logic [31:0]              seed,
  output logic [ID_W-1:0]          tid,
  output logic [(2**DEST_W)-1:0]   dest_en,
  output logic                     irq
);

  localparam int NDEST = 2**DEST_W;

  logic       wr;
  logic [2:0] idx;
  logic       done_q;
  logic [31:0] rd;
  logic       unused_bits;

  assign idx     = paddr[4:2];
  assign wr      = psel & penable & pwrite;
  assign pready  = 1'b1;
  assign pslverr = psel & penable & (idx == REG_BAD);
  assign irq     = done_q & irq_en;
  assign unused_bits = ^{paddr[31:5], paddr[1:0], pwdata};

  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      start_p <= 1'b0;
      stop_p  <= 1'b0;
      cont    <= 1'b0;
      irq_en  <= 1'b0;
      len     <= LEN_W'(LEN_RST);
      npkt    <= '0;
      seed    <= '0;
      tid     <= '0;
      dest_en <= '1;
      done_q  <= 1'b0;
    end else begin
      start_p <= 1'b0;
      stop_p  <= 1'b0;
      if (wr) begin
        case (idx)
          REG_CTRL: begin
            cont    <= pwdata[CTRL_CONT];
            irq_en  <= pwdata[CTRL_IRQ_EN];
            // STOP in the same write suppresses START
            start_p <= pwdata[CTRL_START] & ~pwdata[CTRL_STOP];
            stop_p  <= pwdata[CTRL_STOP];
          end
          REG_LEN:    len     <= pwdata[LEN_W-1:0];
          REG_NPKT:   npkt    <= pwdata[LEN_W-1:0];
          REG_SEED:   seed    <= pwdata;
          REG_CFG: begin
            tid     <= pwdata[ID_W-1:0];
            dest_en <= pwdata[CFG_DEST_LSB +: NDEST];
          end
          REG_STATUS: if (pwdata[STATUS_DONE]) done_q <= 1'b0;
          default: ;
        endcase
      end
      // a completing job wins over a simultaneous clear
      if (done_set) done_q <= 1'b1;
    end
  end

  always_comb begin
    rd = '0;
    case (idx)
      REG_CTRL: begin
        rd[CTRL_CONT]   = cont;
        rd[CTRL_IRQ_EN] = irq_en;
      end
      REG_LEN:  rd = 32'(len);
      REG_NPKT: rd = 32'(npkt);
      REG_SEED: rd = seed;
      REG_CFG: begin
        rd[ID_W-1:0]                = tid;
        rd[CFG_DEST_LSB +: NDEST]   = dest_en;
      end
      REG_STATUS: begin
        rd[STATUS_BUSY]            = busy;
        rd[STATUS_DONE]            = done_q;
        rd[STATUS_PKT_LSB +: 16]   = pkt_count;
      end
      REG_BEATS: rd = beat_count;
      default: rd = '0;
    endcase
    prdata = psel ? rd : 32'd0;
  end

endmodule

// File: rtl/axis_stream_gen.sv
// axis_stream_gen: APB-programmed AXI4-Stream packet generator.
//   APB  : psel, penable, paddr, pwrite, pwdata -> prdata, pready, pslverr
//   AXIS : TREADY in; TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST out
//   irq  : level, DONE sticky & IRQ_EN
// A job is LEN beats x NPKT packets (or endless with CONT) with an
// incrementing payload starting at SEED, TDEST rotating over DEST_EN.
module axis_stream_gen
  import axis_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEST_W = 2,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 16
) (
  input  logic                ACLK,
  input  logic                RSTN,
  input  logic                psel,
  input  logic                penable,
  input  logic [31:0]         paddr,
  input  logic                pwrite,
  input  logic [31:0]         pwdata,
  output logic [31:0]         prdata,
  output logic                pready,
  output logic                pslverr,
  input  logic                TREADY,
  output logic                TVALID,
  output logic [DATA_W-1:0]   TDATA,
  output logic [DATA_W/8-1:0] TSTRB,
  output logic [DATA_W/8-1:0] TKEEP,
  output logic                TLAST,
  output logic [ID_W-1:0]     TID,
  output logic [DEST_W-1:0]   TDEST,
  output logic                irq
);

  localparam int NDEST = 2**DEST_W;

  // live registers
  logic               start_p, stop_p, cont, irq_en;
  logic [LEN_W-1:0]   len, npkt;
  logic [31:0]        seed;
  logic [ID_W-1:0]    tid;
  logic [NDEST-1:0]   dest_en;

  // job state
  gen_state_e         state;
  logic [LEN_W-1:0]   len_sh, npkt_sh, beat_idx, pkt_cnt;
  logic [NDEST-1:0]   dest_mask;
  logic [15:0]        pkt_sat;
  logic [31:0]        beat_total;
  logic               busy_q, stop_req;
  logic               tvalid_q, tlast_q;
  logic [DATA_W-1:0]  tdata_q;
  logic [DEST_W-1:0]  tdest_q;
  logic [ID_W-1:0]    tid_q;

  logic               xfer, stopping, done_set;
  logic [LEN_W-1:0]   len_eff;
  logic [DEST_W-1:0]  first_dest, nxt_dest, cand;
  logic               found;

  axis_gen_apb_regs #(
    .DEST_W (DEST_W),
    .ID_W   (ID_W),
    .LEN_W  (LEN_W)
  ) u_regs (
    .ACLK       (ACLK),
    .RSTN       (RSTN),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .busy       (busy_q),
    .done_set   (done_set),
    .pkt_count  (pkt_sat),
    .beat_count (beat_total),
    .start_p    (start_p),
    .stop_p     (stop_p),
    .cont       (cont),
    .irq_en     (irq_en),
    .len        (len),
    .npkt       (npkt),
    .seed       (seed),
    .tid        (tid),
    .dest_en    (dest_en),
    .irq        (irq)
  );

  assign xfer     = tvalid_q & TREADY;
  // a STOP arriving this very cycle still ends the run at this TLAST
  assign stopping = stop_req | stop_p;
  assign done_set = (state == ST_DONE);
  assign len_eff  = (len == '0) ? LEN_W'(1) : len;

  assign TVALID = tvalid_q;
  assign TDATA  = tdata_q;
  assign TLAST  = tlast_q & tvalid_q;
  assign TID    = tid_q;
  assign TDEST  = tdest_q;
  assign TSTRB  = '1;
  assign TKEEP  = '1;

  // lowest enabled destination from the live mask (used at LOAD)
  always_comb begin
    first_dest = '0;
    for (int i = NDEST-1; i >= 0; i--)
      if (dest_en[i]) first_dest = DEST_W'(i);
  end

  // next enabled destination after the current one; i == NDEST wraps to itself
  always_comb begin
    nxt_dest = tdest_q;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NDEST; i++) begin
      cand = tdest_q + DEST_W'(i);
      if (!found && dest_mask[cand]) begin
        nxt_dest = cand;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      len_sh     <= LEN_W'(LEN_RST);
      npkt_sh    <= '0;
      dest_mask  <= '0;
      beat_idx   <= '0;
      pkt_cnt    <= '0;
      pkt_sat    <= '0;
      beat_total <= '0;
      busy_q     <= 1'b0;
      stop_req   <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tdest_q    <= '0;
      tid_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          stop_req <= 1'b0;
          if (start_p) begin
            state  <= ST_LOAD;
            busy_q <= 1'b1;
          end
        end

        ST_LOAD: begin
          len_sh     <= len_eff;
          npkt_sh    <= npkt;
          dest_mask  <= dest_en;
          tid_q      <= tid;
          tdata_q    <= DATA_W'(seed);
          tdest_q    <= first_dest;
          beat_idx   <= '0;
          pkt_cnt    <= '0;
          pkt_sat    <= '0;
          beat_total <= '0;
          tlast_q    <= (len_eff == LEN_W'(1));
          if (dest_en == '0 || (npkt == '0 && !cont)) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
          end else begin
            state    <= ST_SEND;
            tvalid_q <= 1'b1;
          end
        end

        ST_SEND: begin
          if (xfer) begin
            tdata_q    <= tdata_q + DATA_W'(1);
            beat_total <= beat_total + 32'd1;
            if (tlast_q) begin
              pkt_cnt  <= pkt_cnt + LEN_W'(1);
              pkt_sat  <= sat_inc16(pkt_sat);
              tdest_q  <= nxt_dest;
              beat_idx <= '0;
              tlast_q  <= (len_sh == LEN_W'(1));
              tvalid_q <= 1'b0;
              if (stopping || (!cont && (pkt_cnt + LEN_W'(1)) == npkt_sh)) begin
                state  <= ST_DONE;
                busy_q <= 1'b0;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              beat_idx <= beat_idx + LEN_W'(1);
              tlast_q  <= ((beat_idx + LEN_W'(1)) == (len_sh - LEN_W'(1)));
            end
          end
        end

        ST_GAP: begin
          if (stopping) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
          end else begin
            state    <= ST_SEND;
            tvalid_q <= 1'b1;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase

      if (stop_p && state != ST_IDLE) stop_req <= 1'b1;
    end
  end

endmodule
